bc_score_sequencer: RTL and testbench
=====================================

# bc_score_sequencer

Digit-serial scoring controller for the Bulls & Cows game on the Nexys A7. Accepts a 4-digit guess from the game FSM, validates it, selects the opposing player's secret, and sequences a one-digit-per-cycle bulls/cows comparison. It returns registered bulls, cows and win results through a start/busy/done handshake. It replaces the ad-hoc `verifica` counting inside the top-level game FSM.

## Interface
- No parameters; digit count fixed at 4 (package constant `N_DIGITS`).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; returns block to IDLE and clears all outputs.
- `start`  in  1  request scoring; accepted only in IDLE.
- `player`  in  1  guessing player: 0 = P1 (scored against `secret_p2`), 1 = P2 (scored against `secret_p1`).
- `guess`  in  16  guess digits; d3=[15:12] … d0=[3:0].
- `secret_p1`  in  16  P1 secret, same packing.
- `secret_p2`  in  16  P2 secret, same packing.
- `busy`  out  1  high from the cycle after acceptance until the cycle `done` is high (exclusive).
- `done`  out  1  single-cycle pulse; results valid from this cycle.
- `invalid`  out  1  guess rejected (digit > 9 or repeated digit); valid with `done`.
- `bulls`  out  3  right digit, right position (0–4).
- `cows`  out  3  right digit, wrong position (0–4).
- `win`  out  1  `bulls == 4` and not `invalid`.
- `last_player`  out  1  `player` value of the request that produced the current results.

## Operation
- States: IDLE, CHECK, SCAN, DONE.
- IDLE: on `start`=1, latch `guess`, latch selected secret (mux on `player`), latch `player`, clear the bulls/cows accumulators, go to CHECK.
- CHECK (1 cycle): evaluate guess legality. All four digits must be in 0–9 and pairwise distinct.
  - Illegal: go to DONE with `invalid`=1, bulls=0, cows=0.
  - Legal: clear `idx` to 3, go to SCAN.
- SCAN (4 cycles, `idx` 3→0): compare guess digit `idx` against all secret digits.
  - Equal at the same position: bulls+1.
  - Otherwise, equal at any other position: cows+1.
  - At most one increment per cycle.
  - Go to DONE after `idx`=0.
- Secret legality is the caller's responsibility; a repeated secret digit still yields at most one increment per guess digit.
- DONE (1 cycle): copy accumulators to `bulls`/`cows`, set `win`, `invalid`, `last_player`, pulse `done`. Return to IDLE.
- Outputs `bulls`, `cows`, `win`, `invalid`, `last_player` hold until the next DONE. They are not cleared on `start`.
- `start` while busy or in DONE: ignored, no queuing. Changing `guess`, `secret_*` or `player` after acceptance has no effect.
- Accumulators are 3 bits; the maximum is 4, so they cannot overflow. `bulls`+`cows` ≤ 4.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `invalid`=0, `bulls`=0, `cows`=0, `win`=0, `last_player`=0.
- Legal guess: `start` sampled at edge T0; CHECK T1; SCAN T2–T5; `done`=1 during cycle T6. Latency is 6 cycles.
- Illegal guess: `done`=1 during cycle T2. Latency is 2 cycles.
- `busy`=1 in CHECK and SCAN only. A new `start` is accepted at the earliest at the edge ending the DONE cycle + 1, i.e. from IDLE.
- Back-to-back: `start` held high continuously gives one request per 7 cycles (legal) or per 3 cycles (illegal).
- `reset` asserted mid-SCAN: immediate return to IDLE, all outputs to reset values, no `done` pulse.

## Structure
- Package `bc_pkg` holds:
  - `N_DIGITS`=4, `NULL_DIGIT`=4'hF, `MAX_DIGIT`=4'd9.
  - `typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} score_state_t`.
  - Function `digits_legal(logic [15:0])`, shared with setup-validation in the game FSM.
- One sub-module: `bc_digit_match`, a combinational block taking a 4-bit digit, a 2-bit position and a 16-bit secret, with outputs `is_bull` and `is_cow` (mutually exclusive).
- Game FSM drives `start`/`player`; `bulls`/`cows` feed the LED/7-segment display logic.

## Test plan
- Reset, then `player`=0, `guess`=16'h1234, `secret_p2`=16'h1234 -> `done` at T6, bulls=4, cows=0, win=1, invalid=0, last_player=0.
- `player`=1, `guess`=16'h1234, `secret_p1`=16'h4321 -> bulls=0, cows=4, win=0. Also `secret_p1`=16'h1325 -> bulls=1, cows=2.
- `guess`=16'h1123 and separately 16'h12A4 -> `done` at T2, invalid=1, bulls=0, cows=0, busy never seen in SCAN. Previous win cleared to 0.
- `start` pulsed again at T3 and T6 during a legal request, with `guess` changed at T1 -> exactly one `done`, result reflects the T0 guess. Next request is accepted only from IDLE.
- `reset` asserted at T4 of a legal request -> all outputs 0 the same cycle, no `done`. A fresh request after release completes normally in 6 cycles.
- `start` held high for 21 cycles with alternating `player` -> exactly 3 `done` pulses, 7 cycles apart, `last_player` alternating to match.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared Bulls & Cows constants, scoring FSM state type and the guess legality check.
package bc_pkg;
  localparam int         N_DIGITS   = 4;
  localparam logic [3:0] NULL_DIGIT = 4'hF;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} score_state_t;

  // Legal: every digit in 0-9 and all digits pairwise distinct.
  function automatic logic digits_legal(input logic [15:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (d[i*4 +: 4] > MAX_DIGIT) ok = 1'b0;
      for (int j = i + 1; j < N_DIGITS; j++)
        if (d[i*4 +: 4] == d[j*4 +: 4]) ok = 1'b0;
    end
    return ok;
  endfunction
endpackage

// File: rtl/bc_digit_match.sv
// Classifies one guess digit against the whole secret: bull, cow, or neither.
module bc_digit_match
  import bc_pkg::*;
(
  input  logic [3:0]  digit,
  input  logic [1:0]  pos,
  input  logic [15:0] secret,
  output logic        is_bull,
  output logic        is_cow
);
  logic [N_DIGITS-1:0] hit;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_hit
    assign hit[i] = (secret[i*4 +: 4] == digit);
  end

  // A repeated secret digit still yields a single increment.
  assign is_bull = hit[pos];
  assign is_cow  = !hit[pos] && (|hit);
endmodule

// File: rtl/bc_score_sequencer.sv
// Digit-serial Bulls & Cows scorer: validate guess, then one digit per cycle, with a
// start/busy/done handshake and results held until the next completion.
module bc_score_sequencer
  import bc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        player,
  input  logic [15:0] guess,
  input  logic [15:0] secret_p1,
  input  logic [15:0] secret_p2,
  output logic        busy,
  output logic        done,
  output logic        invalid,
  output logic [2:0]  bulls,
  output logic [2:0]  cows,
  output logic        win,
  output logic        last_player
);
  score_state_t state;
  logic [15:0]  guess_q, secret_q;
  logic         player_q;
  logic [2:0]   acc_bulls, acc_cows;
  logic [1:0]   idx;
  logic         is_bull, is_cow;
  logic [2:0]   nxt_bulls, nxt_cows;

  bc_digit_match u_match (
    .digit   (guess_q[{idx, 2'b00} +: 4]),
    .pos     (idx),
    .secret  (secret_q),
    .is_bull (is_bull),
    .is_cow  (is_cow)
  );

  assign nxt_bulls = acc_bulls + {2'b00, is_bull};
  assign nxt_cows  = acc_cows  + {2'b00, is_cow};

  assign busy = (state == CHECK) || (state == SCAN);
  assign done = (state == DONE);

  // Results are registered on the edge entering DONE so they are valid with the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      guess_q     <= {N_DIGITS{NULL_DIGIT}};
      secret_q    <= {N_DIGITS{NULL_DIGIT}};
      player_q    <= 1'b0;
      acc_bulls   <= 3'd0;
      acc_cows    <= 3'd0;
      idx         <= 2'd0;
      invalid     <= 1'b0;
      bulls       <= 3'd0;
      cows        <= 3'd0;
      win         <= 1'b0;
      last_player <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          guess_q   <= guess;
          secret_q  <= player ? secret_p1 : secret_p2;
          player_q  <= player;
          acc_bulls <= 3'd0;
          acc_cows  <= 3'd0;
          state     <= CHECK;
        end
        CHECK: if (!digits_legal(guess_q)) begin
          invalid     <= 1'b1;
          bulls       <= 3'd0;
          cows        <= 3'd0;
          win         <= 1'b0;
          last_player <= player_q;
          state       <= DONE;
        end else begin
          idx   <= 2'd3;
          state <= SCAN;
        end
        SCAN: begin
          acc_bulls <= nxt_bulls;
          acc_cows  <= nxt_cows;
          idx       <= idx - 2'd1;
          if (idx == 2'd0) begin
            bulls       <= nxt_bulls;
            cows        <= nxt_cows;
            win         <= (nxt_bulls == 3'd4);
            invalid     <= 1'b0;
            last_player <= player_q;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bc_score_sequencer.sv
// Bench for bc_score_sequencer: countdown-based reference model checked every cycle,
// plus directed requests with hand-computed results.
module tb_bc_score_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        player = 1'b0;
  logic [15:0] guess = 16'h0000;
  logic [15:0] secret_p1 = 16'h0000;
  logic [15:0] secret_p2 = 16'h0000;
  logic        busy, done, invalid, win, last_player;
  logic [2:0]  bulls, cows;

  int n_vec = 0;
  int n_err = 0;

  bc_score_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .player(player), .guess(guess),
    .secret_p1(secret_p1), .secret_p2(secret_p2), .busy(busy), .done(done),
    .invalid(invalid), .bulls(bulls), .cows(cows), .win(win), .last_player(last_player)
  );

  always #5 clock = ~clock;

  // {legal, bulls[2:0], cows[2:0]} from the game rules
  function automatic logic [6:0] ref_score(input logic [15:0] g, input logic [15:0] s);
    int b, c;
    logic legal, other;
    legal = 1'b1;
    b = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i*4 +: 4] > 4'd9) legal = 1'b0;
      for (int j = 0; j < 4; j++)
        if (i != j && g[i*4 +: 4] == g[j*4 +: 4]) legal = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      other = 1'b0;
      for (int j = 0; j < 4; j++)
        if (j != i && s[j*4 +: 4] == g[i*4 +: 4]) other = 1'b1;
      if (s[i*4 +: 4] == g[i*4 +: 4]) b++;
      else if (other) c++;
    end
    if (!legal) begin
      b = 0;
      c = 0;
    end
    return {legal, b[2:0], c[2:0]};
  endfunction

  // Model: cycles remaining until the request leaves the block; 1 means done cycle.
  int         m_left = 0;
  logic [2:0] m_pb = 0, m_pc = 0, m_bulls = 0, m_cows = 0;
  logic       m_pinv = 0, m_pp = 0, m_inv = 0, m_win = 0, m_lp = 0;

  always @(posedge clock or posedge reset) begin
    logic [6:0] r;
    if (reset) begin
      m_left <= 0; m_bulls <= 0; m_cows <= 0; m_inv <= 0; m_win <= 0; m_lp <= 0;
    end else if (m_left == 0) begin
      if (start) begin
        r = ref_score(guess, player ? secret_p1 : secret_p2);
        m_pb   <= r[5:3];
        m_pc   <= r[2:0];
        m_pinv <= !r[6];
        m_pp   <= player;
        m_left <= r[6] ? 6 : 2;
      end
    end else begin
      if (m_left == 2) begin
        m_bulls <= m_pb;
        m_cows  <= m_pc;
        m_inv   <= m_pinv;
        m_win   <= !m_pinv && (m_pb == 3'd4);
        m_lp    <= m_pp;
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clock) begin
    logic [10:0] act, exp;
    act = {busy, done, invalid, bulls, cows, win, last_player};
    exp = {m_left > 1, m_left == 1, m_inv, m_bulls, m_cows, m_win, m_lp};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle_compare t=%0t: dut {busy,done,inv,b,c,win,lp}=%b model=%b", $time, act, exp);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and wait for done; lat counts cycles from the accepting edge.
  task automatic req(input logic p, input logic [15:0] g, output int lat);
    @(negedge clock);
    player = p; guess = g; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, nd, ppos, pos[$], lp[$];
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {done, invalid, bulls, cows, win, last_player}, 0);
    reset = 1'b0;

    secret_p2 = 16'h1234;
    req(1'b0, 16'h1234, lat);
    chk("win_latency", lat, 6);
    chk("win_bulls", bulls, 4);
    chk("win_cows", cows, 0);
    chk("win_flags", {win, invalid, last_player}, 3'b100);

    req(1'b0, 16'h1123, lat);
    chk("dup_latency", lat, 2);
    chk("dup_flags", {invalid, win}, 2'b10);
    chk("dup_bc", {bulls, cows}, 0);

    secret_p1 = 16'h4321;
    req(1'b1, 16'h1234, lat);
    chk("rev_bc", {bulls, cows}, {3'd0, 3'd4});
    chk("rev_flags", {win, invalid, last_player}, 3'b001);

    secret_p1 = 16'h1325;
    req(1'b1, 16'h1234, lat);
    chk("mix_bc", {bulls, cows}, {3'd1, 3'd2});

    req(1'b0, 16'h12A4, lat);
    chk("hex_latency", lat, 2);
    chk("hex_flags", {invalid, bulls, cows, last_player}, 8'b1000_0000);

    // Extra starts during a request and a guess change after acceptance are ignored.
    secret_p2 = 16'h1243;
    @(negedge clock);
    player = 1'b0; guess = 16'h1234; start = 1'b1;
    @(negedge clock);
    start = 1'b0; guess = 16'h5678;
    nd = 0;
    for (int k = 2; k <= 13; k++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        chk("noise_bc", {bulls, cows}, {3'd2, 3'd2});
        chk("noise_latency", k, 6);
      end
      start = (k == 3 || k == 6);
    end
    start = 1'b0;
    chk("noise_done_count", nd, 1);

    // Reset mid-SCAN clears outputs at once and suppresses done.
    secret_p1 = 16'h1234;
    @(negedge clock);
    player = 1'b1; guess = 16'h1234; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("rst_outputs", {busy, done, invalid, bulls, cows, win, last_player}, 0);
    @(negedge clock);
    reset = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("rst_no_done", nd, 0);
    req(1'b1, 16'h1234, lat);
    chk("rst_fresh_latency", lat, 6);
    chk("rst_fresh_win", {win, bulls, last_player}, {1'b1, 3'd4, 1'b1});

    // start held for 21 cycles: one request per 7 cycles, player alternating.
    secret_p2 = 16'h1234;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clock);
      if (k > 0 && done) begin
        pos.push_back(k);
        lp.push_back(int'(last_player));
      end
      player = ((k / 7) % 2) == 1;
      start = 1'b1;
    end
    @(negedge clock);
    if (done) begin
      pos.push_back(21);
      lp.push_back(int'(last_player));
    end
    start = 1'b0;
    chk("held_done_count", pos.size(), 3);
    ppos = 0;
    for (int i = 0; i < pos.size() && i < 3; i++) begin
      if (i > 0) chk("held_spacing", pos[i] - ppos, 7);
      chk("held_last_player", lp[i], i % 2);
      ppos = pos[i];
    end
    repeat (10) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
